// File: rtl/dsp48a1_mac_sequencer.sv
// Multiply-accumulate sequencer for one DSP48A1 slice: streams operand pairs into the
// slice, aligns OPMODE with the P stage through a flag pipeline, and returns the dot product.
module dsp48a1_mac_sequencer #(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic [47:0]      result,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic             dsp_ce,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_rst_p,
  input  logic [47:0]      dsp_p
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_LOAD  | clear slice P register and flag pipeline
  // S_FEED  | accept operand pairs; slice CE follows the handshake
  // S_DRAIN | flush the last products through the slice pipeline
  // S_DONE  | present result with a one-cycle done pulse
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

  localparam int DW = $clog2(PIPE_LAT);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT - 2);

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    count;
  logic [DW-1:0]       drain_cnt;
  logic                zero_job;
  logic [47:0]         result_q;
  logic [PIPE_LAT-2:0] v_pipe, f_pipe;
  logic [PIPE_LAT-1:0] v_shift, f_shift;
  logic                hs, last, v_in, f_in;

  assign dsp_a   = in_a;
  assign dsp_b   = in_b;
  assign hs      = in_valid & in_ready;
  assign last    = (count == len_q - LEN_W'(1));
  assign v_in    = hs;
  assign f_in    = hs & (count == '0);
  assign v_shift = {v_pipe, v_in};
  assign f_shift = {f_pipe, f_in};

  // Tail of the flag pipeline lines up with the product arriving at the P stage.
  assign dsp_opmode = !v_pipe[PIPE_LAT-2] ? 8'h08 :
                      f_pipe[PIPE_LAT-2]  ? 8'h01 : 8'h09;

  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    in_ready  = 1'b0;
    dsp_ce    = 1'b0;
    dsp_rst_p = 1'b0;
    result    = result_q;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (len == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        dsp_rst_p = 1'b1;
        state_nxt = S_FEED;
      end
      S_FEED: begin
        in_ready = 1'b1;
        dsp_ce   = in_valid;
        if (in_valid && last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        dsp_ce = 1'b1;
        if (drain_cnt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        result    = zero_job ? 48'd0 : dsp_p;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      count     <= '0;
      drain_cnt <= '0;
      zero_job  <= 1'b0;
      result_q  <= '0;
      v_pipe    <= '0;
      f_pipe    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        len_q    <= len;
        zero_job <= (len == '0);
      end
      if (state == S_LOAD) begin
        count  <= '0;
        v_pipe <= '0;
        f_pipe <= '0;
      end else begin
        if (hs) count <= count + LEN_W'(1);
        if (dsp_ce) begin
          v_pipe <= v_shift[PIPE_LAT-2:0];
          f_pipe <= f_shift[PIPE_LAT-2:0];
        end
      end
      if (hs && last) drain_cnt <= DRAIN_INIT;
      else if (state == S_DRAIN && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
      if (state == S_DONE) result_q <= result;
    end
  end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer: behavioural DSP48A1 slice, directed jobs, and a
// scoreboard of expected results/done cycles checked by an independent done monitor.
module tb_dsp48a1_mac_sequencer;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 4;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  len;
  logic [17:0] in_a, in_b;
  logic        busy, done, in_ready, dsp_ce, dsp_rst_p;
  logic [47:0] result, dsp_p;
  logic [17:0] dsp_a, dsp_b;
  logic [7:0]  dsp_opmode;

  dsp48a1_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy), .done(done),
    .result(result), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_ce(dsp_ce), .dsp_opmode(dsp_opmode),
    .dsp_rst_p(dsp_rst_p), .dsp_p(dsp_p)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slice model: A/B two register stages, M register, P accumulator (4 CE edges).
  logic signed [17:0] a0, b0, a1, b1;
  logic signed [35:0] m;
  logic [47:0]        p;
  always @(posedge clk) begin
    if (dsp_ce) begin
      a0 <= dsp_a; b0 <= dsp_b;
      a1 <= a0;    b1 <= b0;
      m  <= a1 * b1;
    end
    if (dsp_rst_p) p <= '0;
    else if (dsp_ce) begin
      case (dsp_opmode)
        8'h01:   p <= {{12{m[35]}}, m};
        8'h09:   p <= p + {{12{m[35]}}, m};
        default: p <= p;
      endcase
    end
  end
  assign dsp_p = p;

  typedef struct {logic [47:0] res; int cyc;} exp_t;
  exp_t sb[$];
  logic [7:0] op_log[$];
  int n_cmp = 0, n_bad = 0;
  int ce_cnt, rst_cnt, rst_cyc, hs_cnt, drn_cnt, done_cnt = 0;
  int last_start;
  logic signed [17:0] ja[256], jb[256];

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: activity counters and scoreboard pop on done.
  always @(negedge clk) begin
    if (dsp_ce) begin ce_cnt++; op_log.push_back(dsp_opmode); end
    if (dsp_rst_p) begin rst_cnt++; rst_cyc = cyc; end
    if (in_valid && in_ready) hs_cnt++;
    if (busy && !in_ready && dsp_ce) drn_cnt++;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 48'd1, 48'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("done_cycle", 48'(cyc), 48'(e.cyc));
      end
    end
  end

  task automatic clear_stats();
    ce_cnt = 0; rst_cnt = 0; rst_cyc = -1; hs_cnt = 0; drn_cnt = 0;
    op_log.delete();
  endtask

  // Called at posedge+#1 in an IDLE cycle.
  task automatic do_job(input int n, input int stall, input logic [47:0] exp, input bit b2b);
    int lat, guard;
    bit hs;
    lat = (n == 0) ? 1 : 2 + n + (PIPE_LAT - 1) + stall * (n - 1);
    start = 1'b1; len = 8'(n); last_start = cyc;
    sb.push_back('{exp, cyc + lat});
    @(posedge clk) #1;
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        in_valid = 1'b0;
        repeat (stall) @(posedge clk) #1;
      end
      in_valid = 1'b1; in_a = ja[i]; in_b = jb[i];
      guard = 0;
      do begin
        @(negedge clk); hs = in_ready;
        @(posedge clk) #1; guard++;
      end while (!hs && guard < 100);
      if (!hs) chk("handshake_timeout", 48'd0, 48'd1);
    end
    in_valid = 1'b0;
    if (b2b) begin
      start = 1'b1; len = 8'd7;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!done && guard < 2000);
      if (!done) chk("done_timeout", 48'd0, 48'd1);
      @(posedge clk) #1;
      start = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin @(negedge clk); guard++; end while (busy && guard < 2000);
    if (busy) chk("idle_timeout", 48'd1, 48'd0);
    @(posedge clk) #1;
  endtask

  initial begin
    logic [7:0] exp_op [6];
    int dsnap;
    exp_op = '{8'h08, 8'h08, 8'h08, 8'h01, 8'h09, 8'h09};
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 48'(busy), 48'd0);
    chk("rst_done", 48'(done), 48'd0);
    chk("rst_in_ready", 48'(in_ready), 48'd0);
    chk("rst_ce", 48'(dsp_ce), 48'd0);
    chk("rst_rst_p", 48'(dsp_rst_p), 48'd0);
    chk("rst_result", result, 48'd0);
    chk("rst_opmode", 48'(dsp_opmode), 48'h08);
    @(posedge clk) #1;

    // Job 1: len=3, continuous valid -> 19, done at cycle 8.
    ja[0] = 18'sd2;  jb[0] = 18'sd3;
    ja[1] = 18'sd4;  jb[1] = 18'sd5;
    ja[2] = -18'sd1; jb[2] = 18'sd7;
    clear_stats();
    do_job(3, 0, 48'd19, 1'b0);
    wait_idle();
    chk("op_count", 48'(op_log.size()), 48'd6);
    for (int i = 0; i < 6; i++) chk("opmode_seq", 48'(op_log[i]), 48'(exp_op[i]));
    chk("rst_p_count", 48'(rst_cnt), 48'd1);
    chk("rst_p_cycle", 48'(rst_cyc), 48'(last_start + 1));

    // Job 2: same pairs, 2 stall cycles between pairs -> done at cycle 12.
    clear_stats();
    do_job(3, 2, 48'd19, 1'b0);
    wait_idle();
    chk("stall_ce_count", 48'(ce_cnt), 48'd6);
    chk("stall_op_count", 48'(op_log.size()), 48'd6);

    // Job 3: len=0 -> done at cycle 1, result 0, slice untouched.
    clear_stats();
    do_job(0, 0, 48'd0, 1'b0);
    wait_idle();
    chk("len0_ce", 48'(ce_cnt), 48'd0);
    chk("len0_rst_p", 48'(rst_cnt), 48'd0);

    // Back-to-back: (3,3),(3,3) -> 18; start held through DRAIN/DONE is ignored; then (-5,4) -> -20.
    ja[0] = 18'sd3; jb[0] = 18'sd3;
    ja[1] = 18'sd3; jb[1] = 18'sd3;
    do_job(2, 0, 48'd18, 1'b1);
    ja[0] = -18'sd5; jb[0] = 18'sd4;
    do_job(1, 0, 48'hFFFF_FFFF_FFEC, 1'b0);
    wait_idle();

    // Reset during the second FEED cycle aborts the job.
    dsnap = done_cnt;
    ja[0] = 18'sd1; jb[0] = 18'sd2;
    start = 1'b1; len = 8'd3;
    @(posedge clk) #1; start = 1'b0; in_valid = 1'b1; in_a = ja[0]; in_b = jb[0];
    @(posedge clk) #1;
    @(posedge clk) #1; reset = 1'b1;
    @(posedge clk) #1; reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", 48'(busy), 48'd0);
    chk("abort_in_ready", 48'(in_ready), 48'd0);
    chk("abort_result", result, 48'd0);
    repeat (6) @(posedge clk);
    #1 chk("abort_no_done", 48'(done_cnt), 48'(dsnap));
    ja[0] = 18'sd7; jb[0] = 18'sd7;
    do_job(1, 0, 48'd49, 1'b0);
    wait_idle();

    // Full-length job at the most negative operand.
    for (int i = 0; i < 255; i++) begin ja[i] = -18'sd131072; jb[i] = -18'sd131072; end
    clear_stats();
    do_job(255, 0, 48'h03FC_0000_0000, 1'b0);
    wait_idle();
    chk("max_handshakes", 48'(hs_cnt), 48'd255);
    chk("max_drain", 48'(drn_cnt), 48'd3);

    repeat (10) @(posedge clk);
    #1;
    chk("sb_empty", 48'(sb.size()), 48'd0);
    chk("done_total", 48'(done_cnt), 48'd7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
